emu_dec_ctrl: RTL and testbench
===============================

Name: emu_dec_ctrl

Overview:
Decimation and capture-window controller driven by the emulation clock. It consumes the decimation threshold produced by the VIO stage and generates a periodic decimation strobe. It also generates a gated probe-enable that the waveform/probe capture logic uses to record one sample per decimation period, within an armed, triggered window of programmable length. It sits directly downstream of the VIO/clock generation, beside the emulation-control probes.

Parameters:
dec_bits, 24, width of decimation threshold and counter
win_bits, 16, width of capture window length / sample counter

Ports:
emu_clk  input  1  emulation clock; all state on rising edge
emu_rst  input  1  reset, synchronous to emu_clk, active-high
emu_dec_thr  input  dec_bits  decimation threshold; period = emu_dec_thr+1 cycles
arm  input  1  single-cycle request to arm the capture window
trig  input  1  trigger; starts capture when armed
win_len  input  win_bits  decimated samples per window; 0 = unbounded
emu_dec_cmp  output  1  registered decimation strobe, one cycle per period
emu_probe_en  output  1  emu_dec_cmp AND state==CAPTURE
dec_cnt  output  dec_bits  current decimation count
samp_cnt  output  win_bits  samples captured in current window
cap_state  output  2  0=IDLE 1=ARMED 2=CAPTURE 3=DONE
cap_done  output  1  high while state==DONE

Behaviour:
- Reset (emu_rst=1 at edge): dec_cnt=0, emu_dec_cmp=0, thr_q<=emu_dec_thr, samp_cnt=0, win_q=0, state=IDLE. All outputs low/zero except thr_q, which is loaded. Reset mid-capture aborts the window with no residual probe_en.
- Decimation counter, each edge out of reset:
  - if dec_cnt >= thr_q: dec_cnt<=0, emu_dec_cmp<=1, thr_q<=emu_dec_thr
  - else: dec_cnt<=dec_cnt+1, emu_dec_cmp<=0
- The first strobe is asserted after edge thr+1 following reset release. Period is exactly thr_q+1 cycles.
- thr=0: emu_dec_cmp is continuously high from the first edge after reset.
- Threshold changes take effect only at wrap (shadowed in thr_q); the current period is never shortened or extended.
- Use >= compare, not ==, so an out-of-range count can never hang the counter.
- dec_cnt is unsigned, wraps only via threshold; no overflow is possible.
- Capture FSM:
  - IDLE: arm -> ARMED. trig ignored.
  - ARMED: trig -> CAPTURE; samp_cnt<=0; win_q<=win_len. arm ignored.
  - CAPTURE: each cycle with emu_dec_cmp=1, samp_cnt<=samp_cnt+1.
    - if win_q!=0 and samp_cnt+1==win_q: -> DONE.
    - win_q=0: stays in CAPTURE until reset; samp_cnt saturates at all-ones.
    - arm and trig ignored.
  - DONE: cap_done=1; samp_cnt held. arm -> ARMED. trig ignored.
- A strobe in the same cycle as the accepted trig is not captured (state is still ARMED). The first captured strobe is the next one.
- emu_probe_en is combinational from registered state and emu_dec_cmp. It is glitch-free and asserts exactly win_q times per bounded window.
- Simultaneous arm+trig in IDLE or DONE: -> ARMED only; a later trig is required.
- win_len changes after the trig is accepted have no effect on the current window.

Test Plan:
1. Reset, then emu_dec_thr=3, no arm -> emu_dec_cmp high after edges 4, 8, 12; dec_cnt sequence 1,2,3,0,1...; emu_probe_en stays 0.
2. emu_dec_thr=0 -> emu_dec_cmp=1 every cycle. Change thr to 5 while dec_cnt=2 under thr=9 -> current period stays 10 cycles, the next period is 6.
3. thr=1, win_len=3; arm, then trig 4 cycles later -> state IDLE->ARMED->CAPTURE; exactly 3 emu_probe_en pulses spaced 2 cycles apart; samp_cnt=3; cap_done=1.
4. arm and trig in the same cycle from IDLE -> ARMED, no capture. A trig 2 cycles later starts capture. A trig coinciding with a strobe does not count that strobe.
5. win_len=0, thr=0, run 70000 cycles -> remains in CAPTURE; samp_cnt saturates at 0xFFFF; emu_probe_en continuous.
6. Assert emu_rst mid-CAPTURE with samp_cnt=2 -> next cycle: state IDLE, samp_cnt=0, dec_cnt=0, emu_dec_cmp=0, emu_probe_en=0. Re-arm from DONE works after completion.

Source files
------------

// File: rtl/emu_dec_ctrl.sv
// emu_dec_ctrl: decimation strobe generator and capture-window controller.
// A shadowed threshold sets the strobe period. A four-state FSM (idle,
// armed, capture, done) gates that strobe into a probe enable, so that
// exactly one sample is recorded per decimation period inside the window.
module emu_dec_ctrl #(
    parameter int dec_bits = 24,
    parameter int win_bits = 16
) (
    input  logic                emu_clk,
    input  logic                emu_rst,
    input  logic [dec_bits-1:0] emu_dec_thr,
    input  logic                arm,
    input  logic                trig,
    input  logic [win_bits-1:0] win_len,
    output logic                emu_dec_cmp,
    output logic                emu_probe_en,
    output logic [dec_bits-1:0] dec_cnt,
    output logic [win_bits-1:0] samp_cnt,
    output logic [1:0]          cap_state,
    output logic                cap_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [dec_bits-1:0] DEC_ONE  = {{(dec_bits-1){1'b0}}, 1'b1};
    localparam logic [win_bits:0]   SAMP_ONE = {{win_bits{1'b0}}, 1'b1};

    logic [dec_bits-1:0] dec_cnt_q, dec_cnt_d;
    logic                dec_cmp_q, dec_cmp_d;
    logic [dec_bits-1:0] thr_q, thr_d;
    logic [win_bits-1:0] samp_cnt_q, samp_cnt_d;
    logic [win_bits-1:0] win_q, win_d;
    cap_state_t          state_q, state_d;

    // One extra bit so the window-end compare cannot wrap at the all-ones count.
    logic [win_bits:0]   samp_inc;
    logic                win_end;

    assign samp_inc = {1'b0, samp_cnt_q} + SAMP_ONE;
    assign win_end  = (win_q != '0) && (samp_inc == {1'b0, win_q});

    // Decimation counter: wrap and strobe at the shadowed threshold, then reload it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        dec_cnt_d = dec_cnt_q + DEC_ONE;
        dec_cmp_d = 1'b0;
        thr_d     = thr_q;
        // Compare with >= so that a count beyond the threshold still wraps.
        if (dec_cnt_q >= thr_q) begin
            dec_cnt_d = '0;
            dec_cmp_d = 1'b1;
            thr_d     = emu_dec_thr;
        end
    end

    // Capture FSM: next state, sample counter and latched window length.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        win_d      = win_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A strobe in this cycle is not captured; capture starts on the next one.
                if (trig) begin
                    state_d    = ST_CAPTURE;
                    samp_cnt_d = '0;
                    win_d      = win_len;
                end
            end
            ST_CAPTURE: begin
                if (dec_cmp_q) begin
                    // An unbounded window saturates the counter and stays in capture.
                    if (!(&samp_cnt_q)) samp_cnt_d = samp_inc[win_bits-1:0];
                    if (win_end) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers. Reset reloads the threshold shadow and clears everything else.
    always_ff @(posedge emu_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (emu_rst) begin
            dec_cnt_q  <= '0;
            dec_cmp_q  <= 1'b0;
            thr_q      <= emu_dec_thr;
            samp_cnt_q <= '0;
            win_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            dec_cmp_q  <= dec_cmp_d;
            thr_q      <= thr_d;
            samp_cnt_q <= samp_cnt_d;
            win_q      <= win_d;
            state_q    <= state_d;
        end
    end

    // The probe enable is an AND of two flop outputs, so it cannot glitch.
    assign emu_probe_en = dec_cmp_q && (state_q == ST_CAPTURE);
    assign emu_dec_cmp  = dec_cmp_q;
    assign dec_cnt      = dec_cnt_q;
    assign samp_cnt     = samp_cnt_q;
    assign cap_state    = state_q;
    assign cap_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_emu_dec_ctrl.sv
// tb_emu_dec_ctrl: a scoreboard bench for emu_dec_ctrl.
// Each step runs a behavioural model on the driven inputs and queues the
// expected outputs. After the clock edge, the entry is popped and compared
// with the DUT. Directed checks cover the points called out for each scenario.
module tb_emu_dec_ctrl;

    localparam int DB = 24;
    localparam int WB = 16;

    logic          emu_clk = 1'b0;
    logic          emu_rst = 1'b1;
    logic [DB-1:0] emu_dec_thr = '0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [WB-1:0] win_len = '0;
    logic          emu_dec_cmp;
    logic          emu_probe_en;
    logic [DB-1:0] dec_cnt;
    logic [WB-1:0] samp_cnt;
    logic [1:0]    cap_state;
    logic          cap_done;

    emu_dec_ctrl #(.dec_bits(DB), .win_bits(WB)) dut (
        .emu_clk      (emu_clk),
        .emu_rst      (emu_rst),
        .emu_dec_thr  (emu_dec_thr),
        .arm          (arm),
        .trig         (trig),
        .win_len      (win_len),
        .emu_dec_cmp  (emu_dec_cmp),
        .emu_probe_en (emu_probe_en),
        .dec_cnt      (dec_cnt),
        .samp_cnt     (samp_cnt),
        .cap_state    (cap_state),
        .cap_done     (cap_done)
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct packed {
        logic [DB-1:0] cnt;
        logic          cmp;
        logic          probe;
        logic [WB-1:0] samp;
        logic [1:0]    st;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural reference state.
    logic [DB-1:0] m_cnt, m_thr;
    logic          m_cmp;
    logic [WB-1:0] m_samp, m_win;
    logic [1:0]    m_st;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_edge();
        logic old_cmp;
        int   nxt;
        old_cmp = m_cmp;
        if (emu_rst) begin
            m_cnt = '0; m_cmp = 1'b0; m_thr = emu_dec_thr;
            m_samp = '0; m_win = '0; m_st = 2'd0;
        end else begin
            if (m_cnt >= m_thr) begin
                m_cnt = '0; m_cmp = 1'b1; m_thr = emu_dec_thr;
            end else begin
                m_cnt = m_cnt + 1; m_cmp = 1'b0;
            end
            case (m_st)
                2'd0: if (arm) m_st = 2'd1;
                2'd1: if (trig) begin m_st = 2'd2; m_samp = '0; m_win = win_len; end
                2'd2: if (old_cmp) begin
                    nxt = int'(m_samp) + 1;
                    if (m_win != 0 && nxt == int'(m_win)) m_st = 2'd3;
                    if (m_samp != 16'hFFFF) m_samp = m_samp + 1;
                end
                default: if (arm) m_st = 2'd1;
            endcase
        end
    endtask

    // One clock: queue the expected result, then compare after the edge.
    task automatic step(input bit do_chk = 1'b1);
        exp_t e;
        model_edge();
        e.cnt = m_cnt; e.cmp = m_cmp; e.samp = m_samp; e.st = m_st;
        e.probe = m_cmp && (m_st == 2'd2);
        e.done = (m_st == 2'd3);
        sb_q.push_back(e);
        @(posedge emu_clk);
        #1;
        e = sb_q.pop_front();
        if (do_chk) begin
            check("sb_dec_cnt", dec_cnt, e.cnt);
            check("sb_dec_cmp", emu_dec_cmp, e.cmp);
            check("sb_probe_en", emu_probe_en, e.probe);
            check("sb_samp_cnt", samp_cnt, e.samp);
            check("sb_cap_state", cap_state, e.st);
            check("sb_cap_done", cap_done, e.done);
        end
    endtask

    task automatic do_reset(input logic [DB-1:0] thr, input logic [WB-1:0] wl);
        emu_dec_thr = thr; win_len = wl; arm = 0; trig = 0;
        emu_rst = 1; step(); emu_rst = 0;
    endtask

    initial begin
        int k, pulses, last, gap;

        // 1: thr=3, no arm. Strobe after edges 4, 8, 12.
        do_reset(24'd3, 16'd0);
        check("t1_reset_cnt", dec_cnt, 0);
        check("t1_reset_cmp", emu_dec_cmp, 0);
        check("t1_reset_state", cap_state, 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t1_cmp_pattern", emu_dec_cmp, (i % 4 == 0));
            check("t1_cnt_pattern", dec_cnt, i % 4);
            check("t1_probe_low", emu_probe_en, 0);
        end

        // 2: thr=0 strobes every cycle; a mid-period change waits for the wrap.
        do_reset(24'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_thr0_cmp", emu_dec_cmp, 1);
        end
        emu_dec_thr = 24'd9;
        step();                                   // wrap loads 9
        k = 0;
        do begin
            step(); k++;
            if (k == 2) begin
                check("t2_cnt_at_change", dec_cnt, 2);
                emu_dec_thr = 24'd5;
            end
        end while (!emu_dec_cmp && k < 50);
        check("t2_period_old", k, 10);
        k = 0;
        do begin step(); k++; end while (!emu_dec_cmp && k < 50);
        check("t2_period_new", k, 6);

        // 3: thr=1, win_len=3. Three probe pulses 2 cycles apart, then done.
        do_reset(24'd1, 16'd3);
        arm = 1; step(); arm = 0;
        check("t3_armed", cap_state, 1);
        repeat (3) step();
        trig = 1; step(); trig = 0;
        check("t3_capture", cap_state, 2);
        win_len = 16'd7;                          // must not affect this window
        pulses = 0; last = 0; k = 0;
        while (!cap_done && k < 40) begin
            step(); k++;
            if (emu_probe_en) begin
                if (pulses > 0) begin
                    gap = k - last;
                    check("t3_pulse_gap", gap, 2);
                end
                pulses++; last = k;
            end
        end
        check("t3_done_seen", cap_done, 1);
        check("t3_pulses", pulses, 3);
        check("t3_samp_cnt", samp_cnt, 3);
        check("t3_state_done", cap_state, 3);

        // 4: arm+trig together only arms; a trig on a strobe skips that strobe.
        do_reset(24'd1, 16'd2);
        arm = 1; trig = 1; step(); arm = 0; trig = 0;
        check("t4_armtrig_armed", cap_state, 1);
        step();
        check("t4_still_armed", cap_state, 1);
        k = 0;
        while (!emu_dec_cmp && k < 10) begin step(); k++; end
        check("t4_on_strobe", emu_dec_cmp, 1);
        trig = 1; step(); trig = 0;
        check("t4_capture", cap_state, 2);
        check("t4_samp_zero", samp_cnt, 0);
        step();
        check("t4_samp_not_counted", samp_cnt, 0);
        check("t4_probe_next", emu_probe_en, 1);
        step();
        check("t4_first_sample", samp_cnt, 1);
        k = 0;
        while (!cap_done && k < 20) begin step(); k++; end
        check("t4_done", cap_done, 1);
        check("t4_done_samp", samp_cnt, 2);
        // Re-arm from DONE and run a second window.
        arm = 1; step(); arm = 0;
        check("t4_rearm", cap_state, 1);
        trig = 1; step(); trig = 0;
        k = 0;
        while (!cap_done && k < 20) begin step(); k++; end
        check("t4_second_done", cap_done, 1);

        // 6: reset mid-capture with samp_cnt=2.
        do_reset(24'd1, 16'd5);
        arm = 1; step(); arm = 0;
        trig = 1; step(); trig = 0;
        k = 0;
        while (samp_cnt != 2 && k < 20) begin step(); k++; end
        check("t6_samp_two", samp_cnt, 2);
        emu_rst = 1; step(); emu_rst = 0;
        check("t6_state", cap_state, 0);
        check("t6_samp", samp_cnt, 0);
        check("t6_cnt", dec_cnt, 0);
        check("t6_cmp", emu_dec_cmp, 0);
        check("t6_probe", emu_probe_en, 0);

        // 5: unbounded window, thr=0. samp_cnt saturates and the probe stays high.
        do_reset(24'd0, 16'd0);
        arm = 1; step(); arm = 0;
        trig = 1; step(); trig = 0;
        for (int i = 0; i < 70000; i++) step((i % 4096) == 0);
        check("t5_state", cap_state, 2);
        check("t5_samp_sat", samp_cnt, 16'hFFFF);
        check("t5_probe", emu_probe_en, 1);
        step();
        check("t5_samp_hold", samp_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
